unified_mem_arbiter: RTL

Arbitrates a single-port synchronous unified memory between the instruction-fetch port (read-only) and the data port (read/write), so the core can run from one memory array. Sits between the fetch and memory stages on the CPU side and the memory array on the memory side. Data accesses win by default. An anti-starvation counter guarantees fetch forward progress. Read data returns one cycle after the grant and is routed to the port that issued the read.

---
 rtl/unified_mem_arbiter_if.sv | 51 +++++
 rtl/unified_mem_arbiter.sv | 79 +++++++
 2 files changed

// File: rtl/unified_mem_arbiter_if.sv
// CPU-side and memory-side signal bundle of the unified memory arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory environment.
interface unified_mem_arbiter_if #(
    parameter int NB_WORD = 32,
    parameter int NB_ADDR = 32,
    parameter int NB_CNT  = 16
) ();
    logic               i_if_req;
    logic [NB_ADDR-1:0] i_if_addr;
    logic               o_if_gnt;
    logic               o_if_rvalid;
    logic [NB_WORD-1:0] o_if_rdata;

    logic               i_d_req;
    logic               i_d_we;
    logic [3:0]         i_d_be;
    logic [NB_ADDR-1:0] i_d_addr;
    logic [NB_WORD-1:0] i_d_wdata;
    logic               o_d_gnt;
    logic               o_d_rvalid;
    logic [NB_WORD-1:0] o_d_rdata;

    logic               o_mem_en;
    logic               o_mem_we;
    logic [3:0]         o_mem_be;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic [NB_WORD-1:0] o_mem_wdata;
    logic [NB_WORD-1:0] i_mem_rdata;

    logic [NB_CNT-1:0]  o_conflict_cnt;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
        output o_d_gnt, o_d_rvalid, o_d_rdata,
        output o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata,
        output o_conflict_cnt
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
        input  o_d_gnt, o_d_rvalid, o_d_rdata,
        input  o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
        output i_mem_rdata,
        input  o_conflict_cnt
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter: data port wins by default, fetch is forced through
// after MAX_IF_WAIT denied cycles; read data is steered to the port that issued it.
module unified_mem_arbiter #(
    parameter int NB_WORD     = 32,
    parameter int NB_ADDR     = 32,
    parameter int MAX_IF_WAIT = 4,
    parameter int NB_CNT      = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    unified_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic [3:0] MAX_WAIT = 4'(MAX_IF_WAIT);

    logic [3:0]        starve_q, starve_d;
    owner_e            owner_q, owner_d;
    logic [NB_CNT-1:0] conflict_q, conflict_d;

    logic if_gnt, d_gnt, force_if, if_rvalid, d_rvalid;

    always_comb begin
        force_if = (starve_q == MAX_WAIT);
        // Outputs are gated by reset so nothing leaks out while it is held.
        d_gnt    = !i_reset && bus.i_d_req && !(bus.i_if_req && force_if);
        if_gnt   = !i_reset && bus.i_if_req && !d_gnt;

        starve_d = 4'd0;
        if (bus.i_if_req && !if_gnt)
            starve_d = force_if ? starve_q : starve_q + 4'd1;

        owner_d = OWN_NONE;
        if (if_gnt)
            owner_d = OWN_IF;
        else if (d_gnt && !bus.i_d_we)
            owner_d = OWN_D;

        conflict_d = conflict_q;
        if (bus.i_if_req && bus.i_d_req && !(&conflict_q))
            conflict_d = conflict_q + NB_CNT'(1);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            starve_q   <= 4'd0;
            owner_q    <= OWN_NONE;
            conflict_q <= '0;
        end else begin
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            conflict_q <= conflict_d;
        end
    end

    assign if_rvalid = !i_reset && (owner_q == OWN_IF);
    assign d_rvalid  = !i_reset && (owner_q == OWN_D);

    assign bus.o_if_gnt    = if_gnt;
    assign bus.o_d_gnt     = d_gnt;
    assign bus.o_if_rvalid = if_rvalid;
    assign bus.o_d_rvalid  = d_rvalid;
    assign bus.o_if_rdata  = if_rvalid ? bus.i_mem_rdata : {NB_WORD{1'b0}};
    assign bus.o_d_rdata   = d_rvalid  ? bus.i_mem_rdata : {NB_WORD{1'b0}};

    // Fetches are always full-word reads with no write payload.
    assign bus.o_mem_en    = if_gnt | d_gnt;
    assign bus.o_mem_we    = d_gnt & bus.i_d_we;
    assign bus.o_mem_be    = d_gnt ? bus.i_d_be : (if_gnt ? 4'hF : 4'h0);
    assign bus.o_mem_addr  = d_gnt ? bus.i_d_addr :
                             (if_gnt ? bus.i_if_addr : {NB_ADDR{1'b0}});
    assign bus.o_mem_wdata = d_gnt ? bus.i_d_wdata : {NB_WORD{1'b0}};

    assign bus.o_conflict_cnt = i_reset ? {NB_CNT{1'b0}} : conflict_q;
endmodule
